// File: rtl/mem_map_pkg.sv
// mem_map_pkg
//  Address-map defaults, RV32I load/store funct3 encodings, the request hold-register
//  layout and the lsu_req_ctrl state encoding. The lsu address decoder uses the same map.
package mem_map_pkg;

  // Data memory occupies [0, MEM_LIMIT)
  localparam logic [31:0] MEM_LIMIT_DEF = 32'h0000_1000;
  // Output I/O window (LEDR/LEDG/HEX/LCD)
  localparam logic [31:0] IO_BASE_DEF   = 32'h1000_0000;
  localparam logic [31:0] IO_SIZE_DEF   = 32'h0000_5000;
  // Switch window, read-only
  localparam logic [31:0] SW_BASE_DEF   = 32'h1001_0000;
  localparam logic [31:0] SW_SIZE_DEF   = 32'h0000_1000;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ST_WR  = 3'd1,
    LD_REQ = 3'd2,
    LD_CAP = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // Request fields held for the whole transaction
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } lsu_req_t;

endpackage

// File: rtl/mem_region_check.sv
// mem_region_check
//  Combinational classifier for a load/store request.
//  Ports:
//    i_addr      in  32  byte address
//    i_funct3    in  3   RV32I load/store funct3
//    i_we        in  1   1=store, 0=load
//    o_misalign  out 1   access not naturally aligned for its width
//    o_fault     out 1   illegal funct3, unmapped address or disallowed store
//  The two flags are mutually exclusive; misalignment wins.
module mem_region_check
  import mem_map_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT = MEM_LIMIT_DEF,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
  parameter logic [31:0] IO_SIZE   = IO_SIZE_DEF,
  parameter logic [31:0] SW_BASE   = SW_BASE_DEF,
  parameter logic [31:0] SW_SIZE   = SW_SIZE_DEF
) (
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  output logic        o_misalign,
  output logic        o_fault
);

  logic in_mem, in_io, in_sw;
  logic f3_ok, map_ok, mis_raw;

  always_comb begin
    in_mem = (i_addr < MEM_LIMIT);
    in_io  = (i_addr >= IO_BASE) && (i_addr < IO_BASE + IO_SIZE);
    in_sw  = (i_addr >= SW_BASE) && (i_addr < SW_BASE + SW_SIZE);

    if (i_we) f3_ok = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
    else      f3_ok = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);

    mis_raw = 1'b0;
    if ((i_funct3 == F3_H) || (i_funct3 == F3_HU)) mis_raw = i_addr[0];
    else if (i_funct3 == F3_W)                     mis_raw = |i_addr[1:0];

    // I/O outputs only take full-word stores; the switch window never takes stores
    if (i_we) map_ok = in_mem || (in_io && (i_funct3 == F3_W));
    else      map_ok = in_mem || in_io || in_sw;

    // Alignment is only meaningful for a legal width encoding
    o_misalign = f3_ok && mis_raw;
    o_fault    = !o_misalign && (!f3_ok || !map_ok);
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl
//  MEM-stage initiator for the load-store unit. Accepts one request per transaction,
//  classifies it, sequences the lsu strobes around the lsu's one-cycle synchronous read
//  and presents the result on a valid/ready response.
//  Ports:
//    i_clk, i_reset          clock, asynchronous active-low reset
//    i_req_valid/o_req_ready request handshake (ready only in IDLE)
//    i_req_we/addr/wdata/funct3  request fields
//    i_flush                 abandon an outstanding load or response
//    o_rsp_valid/i_rsp_ready response handshake
//    o_rsp_rdata/misalign/fault  response payload (zero outside RESP)
//    o_lsu_addr/o_st_data/o_lsu_wren/o_lsu_ren/o_funct3  to lsu
//    i_ld_data               from lsu, valid the cycle after o_lsu_ren
module lsu_req_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT = MEM_LIMIT_DEF,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
  parameter logic [31:0] SW_BASE   = SW_BASE_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_funct3,
  input  logic        i_flush,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_misalign,
  output logic        o_rsp_fault,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic        o_lsu_ren,
  output logic [2:0]  o_funct3,
  input  logic [31:0] i_ld_data
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        mis_q, mis_d, flt_q, flt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        chk_mis, chk_flt;
  logic        accept, busy, in_resp;

  mem_region_check #(
    .MEM_LIMIT (MEM_LIMIT),
    .IO_BASE   (IO_BASE),
    .IO_SIZE   (IO_SIZE_DEF),
    .SW_BASE   (SW_BASE),
    .SW_SIZE   (SW_SIZE_DEF)
  ) u_chk (
    .i_addr     (i_req_addr),
    .i_funct3   (i_req_funct3),
    .i_we       (i_req_we),
    .o_misalign (chk_mis),
    .o_fault    (chk_flt)
  );

  // A flush cycle never starts a new transaction
  assign accept = i_req_valid && (state_q == IDLE) && !i_flush;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d   = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata, funct3: i_req_funct3};
          mis_d   = chk_mis;
          flt_d   = chk_flt;
          rdata_d = '0;
          if (chk_mis || chk_flt) state_d = RESP;
          else if (i_req_we)      state_d = ST_WR;
          else                    state_d = LD_REQ;
        end
      end
      // The write strobe is already out this cycle, so the store commits regardless of flush
      ST_WR:  state_d = RESP;
      LD_REQ: state_d = i_flush ? IDLE : LD_CAP;
      LD_CAP: begin
        if (i_flush) state_d = IDLE;
        else begin
          rdata_d = i_ld_data;
          state_d = RESP;
        end
      end
      RESP:    if (i_flush || i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
      rdata_q <= rdata_d;
    end
  end

  // Address/funct3 stay on the lsu through LD_CAP so its read mux settles on the same word
  assign busy    = (state_q != IDLE);
  assign in_resp = (state_q == RESP);

  assign o_req_ready    = !busy;
  assign o_lsu_wren     = (state_q == ST_WR);
  assign o_lsu_ren      = (state_q == LD_REQ);
  assign o_lsu_addr     = busy ? req_q.addr   : '0;
  assign o_st_data      = busy ? req_q.wdata  : '0;
  assign o_funct3       = busy ? req_q.funct3 : '0;
  assign o_rsp_valid    = in_resp;
  assign o_rsp_rdata    = in_resp ? rdata_q : '0;
  assign o_rsp_misalign = in_resp && mis_q;
  assign o_rsp_fault    = in_resp && flt_q;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl
//  Directed bench: a small byte-addressed little-endian lsu model answers the strobes;
//  a vector table drives single transactions, hand sequences cover flush, reset and stall.
module tb_lsu_req_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic [2:0]  i_req_funct3 = '0;
  logic        i_flush = 1'b0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_misalign;
  logic        o_rsp_fault;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic        o_lsu_ren;
  logic [2:0]  o_funct3;
  logic [31:0] i_ld_data = '0;

  always #5 i_clk = ~i_clk;

  lsu_req_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_funct3(i_req_funct3), .i_flush(i_flush),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_misalign(o_rsp_misalign), .o_rsp_fault(o_rsp_fault),
    .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren),
    .o_lsu_ren(o_lsu_ren), .o_funct3(o_funct3), .i_ld_data(i_ld_data)
  );

  // ---------------- lsu model ----------------
  logic [7:0]  dmem  [0:4095];
  logic [7:0]  iomem [0:20479];
  logic [31:0] sw_val = 32'h0000_00A5;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] off;
    if (a < 32'h1000) return dmem[a[11:0]];
    if (a >= 32'h1000_0000 && a < 32'h1000_5000) begin
      off = a - 32'h1000_0000;
      return iomem[off[14:0]];
    end
    if (a >= 32'h1001_0000 && a < 32'h1001_1000) return sw_val[8*a[1:0] +: 8];
    return 8'h00;
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
    logic [31:0] off;
    if (a < 32'h1000) dmem[a[11:0]] <= d;
    else if (a >= 32'h1000_0000 && a < 32'h1000_5000) begin
      off = a - 32'h1000_0000;
      iomem[off[14:0]] <= d;
    end
  endtask

  always @(posedge i_clk) begin
    if (o_lsu_wren) begin
      for (int k = 0; k < 4; k++)
        if (k == 0 || (k == 1 && o_funct3 != 3'b000) || o_funct3 == 3'b010)
          wr_byte(o_lsu_addr + 32'(k), o_st_data[8*k +: 8]);
    end
    if (o_lsu_ren) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = rd_byte(o_lsu_addr);
      b1 = rd_byte(o_lsu_addr + 32'd1);
      b2 = rd_byte(o_lsu_addr + 32'd2);
      b3 = rd_byte(o_lsu_addr + 32'd3);
      case (o_funct3)
        3'b000:  i_ld_data <= {{24{b0[7]}}, b0};
        3'b001:  i_ld_data <= {{16{b1[7]}}, b1, b0};
        3'b100:  i_ld_data <= {24'h0, b0};
        3'b101:  i_ld_data <= {16'h0, b1, b0};
        default: i_ld_data <= {b3, b2, b1, b0};
      endcase
    end
  end

  // ---------------- checking ----------------
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [0:NV-1];

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_funct3 = f3;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; returns cycles since accept, or -1 on timeout
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (cyc < 10) begin
      @(negedge i_clk);
      cyc++;
      if (o_rsp_valid) return;
    end
    cyc = -1;
  endtask

  task automatic finish_rsp(input string nm);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1 i_rsp_ready = 1'b0;
    @(negedge i_clk);
    chk({nm, "_ready_after"}, 32'(o_req_ready), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, nw, nr, exp_lat;
    logic done;
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive_req(v.we, v.addr, v.wdata, v.f3);
    cyc = 0; nw = 0; nr = 0; done = 1'b0;
    while (!done && cyc < 10) begin
      @(negedge i_clk);
      cyc++;
      chk({tag, "_strobe_excl"}, 32'(o_lsu_wren & o_lsu_ren), 32'd0);
      if (o_lsu_wren) begin
        nw++;
        chk({tag, "_st_addr"}, o_lsu_addr, v.addr);
        chk({tag, "_st_data"}, o_st_data, v.wdata);
        chk({tag, "_st_f3"}, 32'(o_funct3), 32'(v.f3));
      end
      if (o_lsu_ren) begin
        nr++;
        chk({tag, "_ld_addr"}, o_lsu_addr, v.addr);
        chk({tag, "_ld_f3"}, 32'(o_funct3), 32'(v.f3));
      end
      if (o_rsp_valid) done = 1'b1;
    end
    exp_lat = (v.mis || v.flt) ? 1 : (v.we ? 2 : 3);
    if (!done) chk({tag, "_rsp_timeout"}, 32'(cyc), 32'(exp_lat));
    else begin
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_rdata"}, o_rsp_rdata, v.rdata);
      chk({tag, "_misalign"}, 32'(o_rsp_misalign), 32'(v.mis));
      chk({tag, "_fault"}, 32'(o_rsp_fault), 32'(v.flt));
      chk({tag, "_n_wren"}, 32'(nw), 32'(v.we && !v.mis && !v.flt));
      chk({tag, "_n_ren"}, 32'(nr), 32'(!v.we && !v.mis && !v.flt));
      finish_rsp(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int k = 0; k < 4096; k++) dmem[k] = 8'h00;
    for (int k = 0; k < 20480; k++) iomem[k] = 8'h00;

    //          we    addr           wdata          f3      rdata          mis   flt
    vt[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0103, 32'h0000_0080, 3'b000, 32'h0000_0000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 32'h0000_0103, 32'h0,         3'b000, 32'hFFFF_FF80, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'h0000_0103, 32'h0,         3'b100, 32'h0000_0080, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 32'h0000_0102, 32'h0,         3'b001, 32'hFFFF_80AD, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b101, 32'h0000_BEEF, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 32'h0000_0102, 32'h0,         3'b010, 32'h0000_0000, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 32'h0000_0101, 32'h0,         3'b101, 32'h0000_0000, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 32'h0000_0101, 32'h1234_5678, 3'b001, 32'h0000_0000, 1'b1, 1'b0};
    vt[10] = '{1'b0, 32'h2000_0000, 32'h0,         3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vt[11] = '{1'b1, 32'h1001_0000, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vt[12] = '{1'b0, 32'h1001_0000, 32'h0,         3'b010, 32'h0000_00A5, 1'b0, 1'b0};
    vt[13] = '{1'b1, 32'h1000_0000, 32'h0000_0003, 3'b010, 32'h0000_0000, 1'b0, 1'b0};
    vt[14] = '{1'b0, 32'h1000_0000, 32'h0,         3'b010, 32'h0000_0003, 1'b0, 1'b0};
    vt[15] = '{1'b1, 32'h1000_0000, 32'h0000_0007, 3'b001, 32'h0000_0000, 1'b0, 1'b1};
    vt[16] = '{1'b0, 32'h0000_0100, 32'h0,         3'b011, 32'h0000_0000, 1'b0, 1'b1};
    vt[17] = '{1'b1, 32'h0000_0100, 32'h0000_0009, 3'b011, 32'h0000_0000, 1'b0, 1'b1};
    vt[18] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 3'b010, 32'h0000_0000, 1'b0, 1'b0};
    vt[19] = '{1'b0, 32'h0000_0FFC, 32'h0,         3'b010, 32'h1234_5678, 1'b0, 1'b0};
    vt[20] = '{1'b0, 32'h0000_1000, 32'h0,         3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vt[21] = '{1'b0, 32'h1000_4FFC, 32'h0,         3'b010, 32'h0000_0000, 1'b0, 1'b0};
    vt[22] = '{1'b0, 32'h1000_5000, 32'h0,         3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vt[23] = '{1'b0, 32'h1001_1000, 32'h0,         3'b000, 32'h0000_0000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_strobes", 32'({o_lsu_wren, o_lsu_ren}), 32'd0);
    chk("rst_addr", o_lsu_addr, 32'd0);
    chk("rst_rdata", o_rsp_rdata, 32'd0);
    #3 i_reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

    // Response held stable while the pipeline stalls (word @0x100 is now 0x80ADBEEF)
    drive_req(1'b0, 32'h100, 32'h0, 3'b010);
    wait_rsp(cyc);
    chk("stall_latency", 32'(cyc), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("stall_valid", 32'(o_rsp_valid), 32'd1);
      chk("stall_rdata", o_rsp_rdata, 32'h80AD_BEEF);
      chk("stall_addr", o_lsu_addr, 32'h100);
      chk("stall_ready", 32'(o_req_ready), 32'd0);
    end
    finish_rsp("stall");

    // Flush in LD_REQ
    drive_req(1'b0, 32'h100, 32'h0, 3'b010);
    @(negedge i_clk);
    chk("flreq_ren", 32'(o_lsu_ren), 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    @(negedge i_clk);
    chk("flreq_rsp", 32'(o_rsp_valid), 32'd0);
    chk("flreq_ready", 32'(o_req_ready), 32'd1);

    // Flush in LD_CAP
    drive_req(1'b0, 32'h100, 32'h0, 3'b010);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("flcap_ren", 32'(o_lsu_ren), 32'd0);
    chk("flcap_addr_held", o_lsu_addr, 32'h100);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    @(negedge i_clk);
    chk("flcap_rsp", 32'(o_rsp_valid), 32'd0);
    chk("flcap_ready", 32'(o_req_ready), 32'd1);

    // Flush together with rsp_ready in RESP (misaligned request goes straight to RESP)
    drive_req(1'b0, 32'h101, 32'h0, 3'b010);
    @(negedge i_clk);
    chk("flrsp_valid", 32'(o_rsp_valid), 32'd1);
    i_flush = 1'b1; i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1 begin i_flush = 1'b0; i_rsp_ready = 1'b0; end
    @(negedge i_clk);
    chk("flrsp_idle", 32'({o_req_ready, o_rsp_valid}), 32'b10);

    // Request with flush high in IDLE is not taken
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h100; i_req_funct3 = 3'b010;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 begin i_req_valid = 1'b0; i_flush = 1'b0; end
    @(negedge i_clk);
    chk("flidle_ready", 32'(o_req_ready), 32'd1);
    chk("flidle_ren", 32'(o_lsu_ren), 32'd0);

    // Flush during ST_WR: the store still commits
    drive_req(1'b1, 32'h200, 32'h0000_5A5A, 3'b010);
    @(negedge i_clk);
    chk("flst_wren", 32'(o_lsu_wren), 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rsp_ready = 1'b0;
    @(negedge i_clk);
    chk("flst_ready", 32'(o_req_ready), 32'd1);
    drive_req(1'b0, 32'h200, 32'h0, 3'b010);
    wait_rsp(cyc);
    chk("flst_readback_lat", 32'(cyc), 32'd3);
    chk("flst_readback", o_rsp_rdata, 32'h0000_5A5A);
    finish_rsp("flst");

    // Asynchronous reset in the middle of a load
    drive_req(1'b0, 32'h100, 32'h0, 3'b010);
    @(negedge i_clk);
    chk("arst_ren_before", 32'(o_lsu_ren), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_ren", 32'(o_lsu_ren), 32'd0);
    chk("arst_ready", 32'(o_req_ready), 32'd1);
    chk("arst_addr", o_lsu_addr, 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("arst_rsp", 32'(o_rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
